// File: rtl/fspan_fill.sv
// fspan_fill: multi-lane rectangle span generator, row-major beats with per-lane write mask.
// Optional bound clipping to CLIP_W x CLIP_H when FSPAN_CLIP_EN is defined.
module fspan_fill #(
    parameter int CORDW  = 16,
    parameter int LANES  = 4,
    parameter int CLIP_W = 640,
    parameter int CLIP_H = 480
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    oe,
    input  logic signed [CORDW-1:0] x0,
    input  logic signed [CORDW-1:0] y0,
    input  logic signed [CORDW-1:0] x1,
    input  logic signed [CORDW-1:0] y1,
    output logic signed [CORDW-1:0] x,
    output logic signed [CORDW-1:0] y,
    output logic [LANES-1:0]        mask,
    output logic                    busy,
    output logic                    valid,
    output logic                    done
);
    localparam int W = CORDW + 1;
    localparam logic [0:0] IDLE = 1'b0, DRAW = 1'b1;
    localparam logic signed [W-1:0] ALIGN = ~W'(LANES - 1);
    logic [0:0] state;
    logic signed [W-1:0] xa, xb, xs, yb, xr, yr;
    logic signed [W-1:0] ex0, ex1, ey0, ey1, na, nb, nya, nyb;
    logic empty, row_end;
    // one extra bit keeps x+LANES from wrapping when xb sits at the signed maximum
    assign ex0 = {x0[CORDW-1], x0};
    assign ex1 = {x1[CORDW-1], x1};
    assign ey0 = {y0[CORDW-1], y0};
    assign ey1 = {y1[CORDW-1], y1};
`ifdef FSPAN_CLIP_EN
    localparam logic signed [W-1:0] XMAX = W'(CLIP_W - 1), YMAX = W'(CLIP_H - 1);
    logic signed [W-1:0] ra, rb, rya, ryb;
    always_comb begin
        ra = ex0 < ex1 ? ex0 : ex1;
        rb = ex0 < ex1 ? ex1 : ex0;
        rya = ey0 < ey1 ? ey0 : ey1;
        ryb = ey0 < ey1 ? ey1 : ey0;
        na = ra < 0 ? '0 : ra;
        nb = rb > XMAX ? XMAX : rb;
        nya = rya < 0 ? '0 : rya;
        nyb = ryb > YMAX ? YMAX : ryb;
        empty = na > nb || nya > nyb;
    end
`else
    always_comb begin
        na = ex0 < ex1 ? ex0 : ex1;
        nb = ex0 < ex1 ? ex1 : ex0;
        nya = ey0 < ey1 ? ey0 : ey1;
        nyb = ey0 < ey1 ? ey1 : ey0;
        empty = 1'b0;
    end
`endif
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [W-1:0] p;
        assign p = xr + W'(i);
        assign mask[i] = state == DRAW && p >= xa && p <= xb;
    end
    assign row_end = xr + W'(LANES) > xb;
    assign busy = state == DRAW;
    assign valid = busy && oe;
    assign x = xr[CORDW-1:0];
    assign y = yr[CORDW-1:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done <= 1'b0;
            xr <= '0;
            yr <= '0;
            xa <= '0;
            xb <= '0;
            xs <= '0;
            yb <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && empty) begin
                    done <= 1'b1;
                end else if (start) begin
                    state <= DRAW;
                    xa <= na;
                    xb <= nb;
                    xs <= na & ALIGN;
                    yb <= nyb;
                    xr <= na & ALIGN;
                    yr <= nya;
                end
            end else if (oe) begin
                if (row_end && yr == yb) begin
                    state <= IDLE;
                    done <= 1'b1;
                end else if (row_end) begin
                    yr <= yr + W'(1);
                    xr <= xs;
                end else begin
                    xr <= xr + W'(LANES);
                end
            end
        end
    end
endmodule
